pixel_row_readout_ctrl: RTL

- Sequencing and readout master for one pixel row: drives ERASE/EXPOSE/RAMP/COUNTER/READ into the row and captures its parallel 8-bit-per-pixel data bus.
- Serializes the captured pixels onto a valid/ready stream, one pixel per handshake.
- Sits between the pixel row array and the frame buffer/output logic; one frame per START.

---
 rtl/pixel_row_readout_ctrl_if.sv | 25 ++
 rtl/pixel_row_readout_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/pixel_row_readout_ctrl_if.sv
// Pixel stream bundle between the row readout controller and its sink.
// One pixel per valid/ready handshake, tagged with its column index.
interface pixel_row_readout_ctrl_if #(
  parameter int W  = 2,
  parameter int IW = (W > 1) ? $clog2(W) : 1
);
  logic [7:0]    PIXEL_OUT;
  logic [IW-1:0] PIXEL_INDEX;
  logic          PIXEL_VALID;
  logic          PIXEL_READY;

  modport master (
    output PIXEL_OUT,
    output PIXEL_INDEX,
    output PIXEL_VALID,
    input  PIXEL_READY
  );

  modport slave (
    input  PIXEL_OUT,
    input  PIXEL_INDEX,
    input  PIXEL_VALID,
    output PIXEL_READY
  );
endinterface

// File: rtl/pixel_row_readout_ctrl.sv
// Row sequencer: erase, expose, ramp conversion, read, capture,
// then serialise the captured pixels onto a valid/ready stream.
module pixel_row_readout_ctrl #(
  parameter int PIXEL_ARRAY_WIDTH = 2,
  parameter int ERASE_CYCLES      = 4,
  parameter int EXPOSE_CYCLES     = 10,
  localparam int W  = PIXEL_ARRAY_WIDTH,
  localparam int IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic           START,
  output logic           ERASE,
  output logic           EXPOSE,
  output logic           RAMP,
  output logic [7:0]     COUNTER,
  output logic           READ,
  input  logic [W*8-1:0] DATA_IN,
  output logic           BUSY,
  output logic           FRAME_DONE,
  pixel_row_readout_ctrl_if.master pix
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERASE,
    S_EXPOSE,
    S_CONVERT,
    S_SETTLE,
    S_CAPTURE,
    S_STREAM
  } state_t;

  localparam logic [15:0]   ERASE_LD  = 16'(ERASE_CYCLES - 1);
  localparam logic [15:0]   EXPOSE_LD = 16'(EXPOSE_CYCLES - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(W - 1);

  state_t         state_q, state_d;
  logic [15:0]    cnt_q, cnt_d;
  logic [7:0]     code_q, code_d;
  logic [W*8-1:0] cap_q, cap_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [7:0]     pix_q, pix_d;
  logic           erase_q, erase_d;
  logic           expose_q, expose_d;
  logic           ramp_q, ramp_d;
  logic           read_q, read_d;
  logic           valid_q, valid_d;
  logic           done_q, done_d;
  logic           busy_q, busy_d;
  logic [IW-1:0]  nxt_idx;

  // Next state plus the registered strobes that go with that state.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    code_d   = code_q;
    cap_d    = cap_q;
    idx_d    = idx_q;
    pix_d    = pix_q;
    erase_d  = 1'b0;
    expose_d = 1'b0;
    ramp_d   = 1'b0;
    read_d   = 1'b0;
    valid_d  = 1'b0;
    done_d   = 1'b0;
    nxt_idx  = idx_q + 1'b1;
    unique case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d = S_ERASE;
          cnt_d   = ERASE_LD;
          erase_d = 1'b1;
        end
      end
      S_ERASE: begin
        if (cnt_q == 16'd0) begin
          state_d  = S_EXPOSE;
          cnt_d    = EXPOSE_LD;
          expose_d = 1'b1;
        end else begin
          cnt_d   = cnt_q - 16'd1;
          erase_d = 1'b1;
        end
      end
      S_EXPOSE: begin
        if (cnt_q == 16'd0) begin
          state_d = S_CONVERT;
          code_d  = 8'd0;
          ramp_d  = 1'b1;
        end else begin
          cnt_d    = cnt_q - 16'd1;
          expose_d = 1'b1;
        end
      end
      S_CONVERT: begin
        if (code_q == 8'hFF) begin
          state_d = S_SETTLE;
          read_d  = 1'b1;
        end else begin
          code_d = code_q + 8'd1;
          ramp_d = 1'b1;
        end
      end
      S_SETTLE: begin
        state_d = S_CAPTURE;
        read_d  = 1'b1;
      end
      S_CAPTURE: begin
        state_d = S_STREAM;
        cap_d   = DATA_IN;
        idx_d   = '0;
        pix_d   = DATA_IN[7:0];
        valid_d = 1'b1;
      end
      S_STREAM: begin
        valid_d = 1'b1;
        if (pix.PIXEL_READY) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d = nxt_idx;
            pix_d = cap_q[{nxt_idx, 3'b000} +: 8];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset abandons any frame in flight.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      code_q   <= '0;
      cap_q    <= '0;
      idx_q    <= '0;
      pix_q    <= '0;
      erase_q  <= 1'b0;
      expose_q <= 1'b0;
      ramp_q   <= 1'b0;
      read_q   <= 1'b0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      code_q   <= code_d;
      cap_q    <= cap_d;
      idx_q    <= idx_d;
      pix_q    <= pix_d;
      erase_q  <= erase_d;
      expose_q <= expose_d;
      ramp_q   <= ramp_d;
      read_q   <= read_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign ERASE           = erase_q;
  assign EXPOSE          = expose_q;
  assign RAMP            = ramp_q;
  assign COUNTER         = code_q;
  assign READ            = read_q;
  assign BUSY            = busy_q;
  assign FRAME_DONE      = done_q;
  assign pix.PIXEL_OUT   = pix_q;
  assign pix.PIXEL_INDEX = idx_q;
  assign pix.PIXEL_VALID = valid_q;

endmodule
